// File: rtl/vga_pixel_gen.sv
// Pixel generator: draws a bouncing box over a background and aligns colour with sync.
// Latency: 2 cycles from timing inputs to vga_hs/vga_vs/rgb/frame_tick.
// Backpressure: none; free-running pixel stream. Optional colour bars: VGA_PIXEL_COLOR_BARS_EN.
module vga_pixel_gen #(
   parameter int          H_DISPLAY = 640,
   parameter int          V_DISPLAY = 480,
   parameter int          BOX_SIZE  = 32,
   parameter int          BOX_STEP  = 2,
   parameter logic [11:0] BOX_COLOR = 12'hF80,
   parameter logic [11:0] BG_COLOR  = 12'h008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic        video_on,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic [11:0] rgb,
   output logic        frame_tick
);

   localparam logic [10:0] X_MAX = 11'(H_DISPLAY - BOX_SIZE);
   localparam logic [10:0] Y_MAX = 11'(V_DISPLAY - BOX_SIZE);
   localparam logic [10:0] STEP  = 11'(BOX_STEP);
   localparam logic [10:0] SIZE  = 11'(BOX_SIZE);

   // stage-1 copies of the timing inputs
   logic       s1_hs, s1_vs, s1_von;
   logic [9:0] s1_x, s1_y;
   // previous stage-1 v_sync for edge detection
   logic       s1_vs_prev;
   // primed: stage 1 holds real samples (not reset values); armed: v_sync seen low
   logic       primed, armed;

   logic [9:0] box_x, box_y;
   logic       dir_x, dir_y;

   logic [9:0]  box_x_nxt, box_y_nxt;
   logic        dir_x_nxt, dir_y_nxt;
   logic        hit;
   logic [11:0] bg;
   logic [11:0] pix;
   logic        tick_nxt;

   // stage 1: register raw timing and position
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_von <= 1'b0;
         s1_x   <= '0;
         s1_y   <= '0;
      end else begin
         s1_hs  <= h_sync;
         s1_vs  <= v_sync;
         s1_von <= video_on;
         s1_x   <= pos_x;
         s1_y   <= pos_y;
      end
   end

   // edge-detect bookkeeping; arming ignores the reset value of s1_vs
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vs_prev <= 1'b0;
         primed     <= 1'b0;
         armed      <= 1'b0;
      end else begin
         s1_vs_prev <= s1_vs;
         primed     <= 1'b1;
         armed      <= armed | (primed & ~s1_vs);
      end
   end

   assign tick_nxt = armed & s1_vs & ~s1_vs_prev;

   // box motion: next position/direction per axis, bouncing at the edges
   always_comb begin
      box_x_nxt = box_x;
      dir_x_nxt = dir_x;
      box_y_nxt = box_y;
      dir_y_nxt = dir_y;
      if (dir_x) begin
         if ({1'b0, box_x} + STEP >= X_MAX) begin
            box_x_nxt = X_MAX[9:0];
            dir_x_nxt = 1'b0;
         end else begin
            box_x_nxt = box_x + STEP[9:0];
         end
      end else begin
         if ({1'b0, box_x} <= STEP) begin
            box_x_nxt = '0;
            dir_x_nxt = 1'b1;
         end else begin
            box_x_nxt = box_x - STEP[9:0];
         end
      end
      if (dir_y) begin
         if ({1'b0, box_y} + STEP >= Y_MAX) begin
            box_y_nxt = Y_MAX[9:0];
            dir_y_nxt = 1'b0;
         end else begin
            box_y_nxt = box_y + STEP[9:0];
         end
      end else begin
         if ({1'b0, box_y} <= STEP) begin
            box_y_nxt = '0;
            dir_y_nxt = 1'b1;
         end else begin
            box_y_nxt = box_y - STEP[9:0];
         end
      end
   end

   // box state advances only in the frame_tick cycle, i.e. inside v_sync
   always_ff @(posedge clk) begin
      if (reset) begin
         box_x <= '0;
         box_y <= '0;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (frame_tick) begin
         box_x <= box_x_nxt;
         box_y <= box_y_nxt;
         dir_x <= dir_x_nxt;
         dir_y <= dir_y_nxt;
      end
   end

   // box hit test with 11-bit upper bounds so the box edge never wraps
   assign hit = ({1'b0, s1_x} >= {1'b0, box_x}) && ({1'b0, s1_x} < {1'b0, box_x} + SIZE) &&
                ({1'b0, s1_y} >= {1'b0, box_y}) && ({1'b0, s1_y} < {1'b0, box_y} + SIZE);

`ifdef VGA_PIXEL_COLOR_BARS_EN
   localparam logic [10:0] BAR1 = 11'(1 * (H_DISPLAY / 8));
   localparam logic [10:0] BAR2 = 11'(2 * (H_DISPLAY / 8));
   localparam logic [10:0] BAR3 = 11'(3 * (H_DISPLAY / 8));
   localparam logic [10:0] BAR4 = 11'(4 * (H_DISPLAY / 8));
   localparam logic [10:0] BAR5 = 11'(5 * (H_DISPLAY / 8));
   localparam logic [10:0] BAR6 = 11'(6 * (H_DISPLAY / 8));
   localparam logic [10:0] BAR7 = 11'(7 * (H_DISPLAY / 8));

   // colour bars chosen by threshold compares on the column
   always_comb begin
      bg = 12'h000;
      if      ({1'b0, s1_x} < BAR1) bg = 12'hFFF;
      else if ({1'b0, s1_x} < BAR2) bg = 12'hFF0;
      else if ({1'b0, s1_x} < BAR3) bg = 12'h0FF;
      else if ({1'b0, s1_x} < BAR4) bg = 12'h0F0;
      else if ({1'b0, s1_x} < BAR5) bg = 12'hF0F;
      else if ({1'b0, s1_x} < BAR6) bg = 12'hF00;
      else if ({1'b0, s1_x} < BAR7) bg = 12'h00F;
      else                          bg = 12'h000;
   end
`else
   assign bg = BG_COLOR;
`endif

   // pixel colour: blank outside visible area, box over background
   always_comb begin
      pix = 12'h000;
      if (s1_von) begin
         if (hit) pix = BOX_COLOR;
         else     pix = bg;
      end
   end

   // stage 2: outputs aligned with each other
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_hs     <= 1'b0;
         vga_vs     <= 1'b0;
         rgb        <= 12'h000;
         frame_tick <= 1'b0;
      end else begin
         vga_hs     <= s1_hs;
         vga_vs     <= s1_vs;
         rgb        <= pix;
         frame_tick <= tick_nxt;
      end
   end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: rendering, sync latency, frame tick and box bounce.
module tb_vga_pixel_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        h_sync, v_sync, video_on;
   logic [9:0]  pos_x, pos_y;
   logic        vga_hs, vga_vs, frame_tick;
   logic [11:0] rgb;

   int n_total = 0;
   int n_pass  = 0;

`ifdef VGA_PIXEL_COLOR_BARS_EN
   localparam logic [11:0] EXP_X0   = 12'hFFF;
   localparam logic [11:0] EXP_X32  = 12'hFFF;
   localparam logic [11:0] EXP_X79  = 12'hFFF;
   localparam logic [11:0] EXP_X80  = 12'hFF0;
   localparam logic [11:0] EXP_X639 = 12'h000;
`else
   localparam logic [11:0] EXP_X0   = 12'h008;
   localparam logic [11:0] EXP_X32  = 12'h008;
   localparam logic [11:0] EXP_X79  = 12'h008;
   localparam logic [11:0] EXP_X80  = 12'h008;
   localparam logic [11:0] EXP_X639 = 12'h008;
`endif

   vga_pixel_gen dut (
      .clk        (clk),
      .reset      (reset),
      .h_sync     (h_sync),
      .v_sync     (v_sync),
      .video_on   (video_on),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .rgb        (rgb),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic von,
                      input logic [11:0] exp);
      pos_x    = 10'(x);
      pos_y    = 10'(y);
      video_on = von;
      repeat (2) cyc();
      check(tag, {20'd0, rgb}, {20'd0, exp});
   endtask

   // one v_sync low->high frame boundary; counts cycles frame_tick is high
   task automatic frame(output int hi);
      v_sync = 1'b0;
      repeat (2) cyc();
      v_sync = 1'b1;
      hi = 0;
      repeat (6) begin
         cyc();
         if (frame_tick) hi++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
   endtask

   initial begin
      int hi;
      int bad;
      reset    = 1'b1;
      h_sync   = 1'b0;
      v_sync   = 1'b1;
      video_on = 1'b0;
      pos_x    = '0;
      pos_y    = '0;
      #1;
      repeat (3) cyc();

      // reset state
      check("rst_rgb",   {20'd0, rgb}, 32'h0);
      check("rst_hs",    {31'd0, vga_hs}, 32'h0);
      check("rst_vs",    {31'd0, vga_vs}, 32'h0);
      check("rst_tick",  {31'd0, frame_tick}, 32'h0);
      check("rst_box_x", {22'd0, dut.box_x}, 32'd0);
      check("rst_dir_x", {31'd0, dut.dir_x}, 32'd1);

      // v_sync held high across reset release must not tick
      reset = 1'b0;
      hi = 0;
      repeat (8) begin
         cyc();
         if (frame_tick) hi++;
      end
      check("no_tick_after_rst", hi, 0);

      // first genuine edge gives exactly one single-cycle tick
      frame(hi);
      check("first_tick_cycles", hi, 1);
      check("first_tick_box_x", {22'd0, dut.box_x}, 32'd2);
      check("first_tick_box_y", {22'd0, dut.box_y}, 32'd2);

      // rendering from a clean reset, box at (0,0)
      v_sync = 1'b0;
      do_reset();
      pix("box_0_0",    0,   0, 1'b1, 12'hF80);
      pix("box_31_31",  31,  31, 1'b1, 12'hF80);
      pix("bg_32_0",    32,  0, 1'b1, EXP_X32);
      pix("bg_0_32",    0,   32, 1'b1, EXP_X0);
      pix("bg_79_0",    79,  0, 1'b1, EXP_X79);
      pix("bg_80_0",    80,  0, 1'b1, EXP_X80);
      pix("bg_639_0",   639, 0, 1'b1, EXP_X639);
      pix("blank_5_5",  5,   5, 1'b0, 12'h000);

      // sync latency exactly two cycles
      h_sync = 1'b1;
      cyc();
      check("hs_rise_d1", {31'd0, vga_hs}, 32'd0);
      cyc();
      check("hs_rise_d2", {31'd0, vga_hs}, 32'd1);
      h_sync = 1'b0;
      cyc();
      check("hs_fall_d1", {31'd0, vga_hs}, 32'd1);
      cyc();
      check("hs_fall_d2", {31'd0, vga_hs}, 32'd0);
      v_sync = 1'b1;
      cyc();
      check("vs_rise_d1", {31'd0, vga_vs}, 32'd0);
      cyc();
      check("vs_rise_d2", {31'd0, vga_vs}, 32'd1);

      // long bounce run from (0,0)
      v_sync = 1'b0;
      do_reset();
      bad = 0;
      for (int i = 1; i <= 305; i++) begin
         frame(hi);
         if (hi != 1) bad++;
         if (i == 224) begin
            check("y_224",     {22'd0, dut.box_y}, 32'd448);
            check("dir_y_224", {31'd0, dut.dir_y}, 32'd0);
         end
         if (i == 225) check("y_225", {22'd0, dut.box_y}, 32'd446);
         if (i == 304) begin
            check("x_304",     {22'd0, dut.box_x}, 32'd608);
            check("dir_x_304", {31'd0, dut.dir_x}, 32'd0);
         end
         if (i == 305) check("x_305", {22'd0, dut.box_x}, 32'd606);
      end
      check("tick_pulses_bad", bad, 0);

      // reset mid-motion restarts from origin
      v_sync = 1'b0;
      do_reset();
      for (int i = 0; i < 50; i++) frame(hi);
      check("x_50", {22'd0, dut.box_x}, 32'd100);
      v_sync = 1'b0;
      pix("box_100_100", 100, 100, 1'b1, 12'hF80);
      reset = 1'b1;
      cyc();
      check("mid_rst_rgb",   {20'd0, rgb}, 32'h0);
      check("mid_rst_box_x", {22'd0, dut.box_x}, 32'd0);
      check("mid_rst_box_y", {22'd0, dut.box_y}, 32'd0);
      check("mid_rst_dir_x", {31'd0, dut.dir_x}, 32'd1);
      check("mid_rst_dir_y", {31'd0, dut.dir_y}, 32'd1);
      reset = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_pixel_gen.md
VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-003 Parameter BOX_SIZE, default 32, square edge length in pixels.
REQ-004 Parameter BOX_STEP, default 2, box move per frame per axis in pixels.
REQ-005 Parameter BOX_COLOR, default 12'hF80, box colour in RGB444.
REQ-006 Parameter BG_COLOR, default 12'h008, background colour in RGB444.
REQ-007 clk  in  1  pixel clock; the only clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 h_sync  in  1  timing-stage horizontal sync, active-high.
REQ-010 v_sync  in  1  timing-stage vertical sync, active-high.
REQ-011 video_on  in  1  high inside the visible area.
REQ-012 pos_x  in  10  current pixel column.
REQ-013 pos_y  in  10  current pixel row.
REQ-014 vga_hs  out  1  h_sync delayed 2 cycles, same polarity.
REQ-015 vga_vs  out  1  v_sync delayed 2 cycles, same polarity.
REQ-016 rgb  out  12  pixel colour {R[11:8],G[7:4],B[3:0]}, aligned with vga_hs/vga_vs.
REQ-017 frame_tick  out  1  one-cycle pulse per frame start.

Function
REQ-018 Stage 1 SHALL register h_sync, v_sync, video_on, pos_x, pos_y; stage 2 SHALL register vga_hs, vga_vs, rgb, frame_tick; input-to-output latency is exactly 2 cycles.
REQ-019 Box-hit SHALL be pos_x in [box_x, box_x+BOX_SIZE) and pos_y in [box_y, box_y+BOX_SIZE), evaluated on stage-1 values with 11-bit sums (no wrap).
REQ-020 rgb SHALL be 0 when stage-1 video_on is low; else BOX_COLOR on box-hit; else background (REQ-030).
REQ-021 frame_tick SHALL assert for exactly one cycle, 2 cycles after the input v_sync 0->1 edge, only when armed.
REQ-022 Edge detection SHALL be armed only after stage-1 v_sync has been seen low at least once since reset; v_sync high across reset release SHALL NOT produce a tick.
REQ-023 Box state box_x[9:0], box_y[9:0], dir_x, dir_y (1 = right/down) SHALL update only in the cycle frame_tick is asserted; all other cycles hold.
REQ-024 Moving right: if box_x+BOX_STEP >= H_DISPLAY-BOX_SIZE then box_x <= H_DISPLAY-BOX_SIZE and dir_x <= 0; else box_x <= box_x+BOX_STEP.
REQ-025 Moving left: if box_x <= BOX_STEP then box_x <= 0 and dir_x <= 1; else box_x <= box_x-BOX_STEP.
REQ-026 Y axis SHALL follow REQ-024/025 with box_y, dir_y, V_DISPLAY.
REQ-027 X and Y updates SHALL be independent; simultaneous corner bounce flips both directions in the same tick.
REQ-028 Box position used for rendering SHALL not change within a visible line (updates occur only during v_sync).

Reset
REQ-029 On reset, all stage-1/stage-2 registers, vga_hs, vga_vs, rgb and frame_tick SHALL be 0; box_x=0, box_y=0, dir_x=1, dir_y=1, armed=0; reset mid-frame SHALL abandon motion and restart from (0,0) on the next cycle.

Configuration
REQ-030 Macro VGA_PIXEL_COLOR_BARS_EN: defined -> background is 8 vertical bars of H_DISPLAY/8 px, left to right FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000, selected by comparisons (no divider); undefined -> background is BG_COLOR; box and timing behaviour identical in both builds.

Verification
REQ-031 Reset, then pos=(0,0), video_on=1 -> 2 cycles later rgb=12'hF80; pos=(32,0) -> rgb=12'h008 (bars off) or 12'hFFF (bars on).
REQ-032 video_on=0 at pos=(5,5) -> rgb=0; h_sync/v_sync toggles reproduced on vga_hs/vga_vs exactly 2 cycles later.
REQ-033 Hold v_sync high through reset release -> no frame_tick; then low, then high -> exactly one 1-cycle frame_tick; after it box_x=2, box_y=2.
REQ-034 Issue 304 ticks -> box_x=608, dir_x=0; 305th tick -> box_x=606; 224 ticks -> box_y=448, dir_y=0; 225th -> box_y=446.
REQ-035 Bars on: pos_x=79 -> FFF, pos_x=80 -> FF0, pos_x=639 -> 000 (box moved away from pixel).
REQ-036 Assert reset after 50 ticks -> box_x=0, box_y=0, dir_x=dir_y=1, rgb=0 next cycle.
